// File: rtl/jt053247_pkg.sv
// jt053247_pkg: shared state type and geometry constants for the 053247 tile line drawer
package jt053247_pkg;
    typedef enum logic [1:0] {IDLE, FETCH0, FETCH1, DRAW} state_t;
    localparam int ZUNIT   = 64;
    localparam int TILE_W  = 16;
    localparam int MAX_OUT = 512;
endpackage

// File: rtl/jt053247_hzoom.sv
// jt053247_hzoom: fixed-point horizontal source stepper with end-of-tile detect
module jt053247_hzoom
    import jt053247_pkg::*;
#(
    parameter int ZW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          load,
    input  logic          keep,
    input  logic          adv,
    input  logic [ZW-1:0] hzoom,
    output logic [3:0]    idx,
    output logic          last
);
    localparam int FW    = $clog2(ZUNIT);
    localparam int ACC_W = $clog2(TILE_W * ZUNIT);
    localparam int SUM_W = (ZW > ACC_W ? ZW : ACC_W) + 1;

    logic [ACC_W-1:0] acc;
    logic [ZW-1:0]    step;
    logic [SUM_W-1:0] sum;

    assign step = hzoom == '0 ? ZW'(1) : hzoom;
    assign sum  = SUM_W'(acc) + SUM_W'(step);
    assign last = sum >= SUM_W'(TILE_W * ZUNIT);
    assign idx  = acc[ACC_W-1:FW];

    // Restart (or keep only the fraction) at tile start, then advance one step per output
    always_ff @(posedge clk) begin
        if (rst)
            acc <= '0;
        else if (cen && load)
            acc <= keep ? {{(ACC_W-FW){1'b0}}, acc[FW-1:0]} : '0;
        else if (cen && adv)
            acc <= sum[ACC_W-1:0];
    end
endmodule

// File: rtl/jt053247_draw.sv
// jt053247_draw: draws one 16-pixel sprite tile row into the object line buffer
// Optional: define JT053247_DRAW_HCLIP_EN to suppress writes at x >= 9'h180
module jt053247_draw
    import jt053247_pkg::*;
#(
    parameter int ZW = 10,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          dr_start,
    output logic          dr_busy,
    input  logic [15:0]   code,
    input  logic [AW-1:0] attr,
    input  logic          hflip,
    input  logic          vflip,
    input  logic [8:0]    hpos,
    input  logic [3:0]    ysub,
    input  logic [ZW-1:0] hzoom,
    input  logic          hz_keep,
    output logic [20:0]   rom_addr,
    output logic          rom_cs,
    input  logic          rom_ok,
    input  logic [31:0]   rom_data,
    output logic [8:0]    buf_addr,
    output logic          buf_we,
    output logic [AW+3:0] buf_din
);
    state_t        state, nxt;
    logic [AW-1:0] attr_l;
    logic          hflip_l, keep_l;
    logic [8:0]    hpos_l, x, cnt;
    logic [ZW-1:0] hzoom_l;
    logic [63:0]   pix;
    logic [3:0]    idx, src, px;
    logic          zlast, last, vis;

    jt053247_hzoom #(.ZW(ZW)) u_hzoom (
        .clk   (clk),
        .rst   (rst),
        .cen   (cen),
        .load  (state == FETCH1 && rom_ok),
        .keep  (keep_l),
        .adv   (state == DRAW),
        .hzoom (hzoom_l),
        .idx   (idx),
        .last  (zlast)
    );

    // ~idx is the mirrored column 15-idx
    assign src     = hflip_l ? ~idx : idx;
    assign px      = pix[{src, 2'b00} +: 4];
    assign last    = zlast || cnt == 9'(MAX_OUT - 1);
    assign dr_busy = state != IDLE;
    assign rom_cs  = state == FETCH0 || state == FETCH1;
`ifdef JT053247_DRAW_HCLIP_EN
    assign vis = x < 9'h180;
`else
    assign vis = 1'b1;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else if (cen)
            state <= nxt;
    end

    // Next state: start, two ROM words, then draw until the tile or output budget ends
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = dr_start ? FETCH0 : IDLE;
            FETCH0:  nxt = rom_ok ? FETCH1 : FETCH0;
            FETCH1:  nxt = rom_ok ? DRAW : FETCH1;
            DRAW:    nxt = last ? IDLE : DRAW;
            default: nxt = IDLE;
        endcase
    end

    // Object latch, ROM words, x counter and line-buffer write port
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr <= '0;
            buf_we   <= 1'b0;
            buf_addr <= '0;
            buf_din  <= '0;
            x        <= '0;
            cnt      <= '0;
            attr_l   <= '0;
            hflip_l  <= 1'b0;
            keep_l   <= 1'b0;
            hpos_l   <= '0;
            hzoom_l  <= '0;
            pix      <= '0;
        end else begin
            buf_we <= 1'b0;
            if (cen) begin
                case (state)
                    IDLE: if (dr_start) begin
                        rom_addr <= {code, ysub ^ {4{vflip}}, 1'b0};
                        attr_l   <= attr;
                        hflip_l  <= hflip;
                        keep_l   <= hz_keep;
                        hpos_l   <= hpos;
                        hzoom_l  <= hzoom;
                    end
                    FETCH0: if (rom_ok) begin
                        pix[31:0]   <= rom_data;
                        rom_addr[0] <= 1'b1;
                    end
                    FETCH1: if (rom_ok) begin
                        pix[63:32] <= rom_data;
                        x          <= keep_l ? x : hpos_l;
                        cnt        <= '0;
                    end
                    DRAW: begin
                        buf_we   <= px != 4'd0 && vis;
                        buf_addr <= x;
                        buf_din  <= {attr_l, px};
                        x        <= x + 9'd1;
                        cnt      <= cnt + 9'd1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_jt053247_draw.sv
// tb_jt053247_draw: vector table plus scoreboard of expected line-buffer writes
`timescale 1ns/1ps
module tb_jt053247_draw;
    localparam int ZW = 10;
    localparam int AW = 10;
`ifdef JT053247_DRAW_HCLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    typedef struct {
        logic [15:0]   code;
        logic [AW-1:0] attr;
        logic          hflip;
        logic          vflip;
        logic [8:0]    hpos;
        logic [3:0]    ysub;
        logic [ZW-1:0] hz;
        logic          keep;
        logic [31:0]   w0;
        logic [31:0]   w1;
        int            stall;
        logic          cm;
        int            n;
    } vec_t;

    typedef struct packed {
        logic [8:0]    a;
        logic [AW+3:0] d;
    } wr_t;

    logic          clk = 1'b0, rst = 1'b1, cen = 1'b1, dr_start = 1'b0;
    logic          hflip = 1'b0, vflip = 1'b0, hz_keep = 1'b0, rom_ok = 1'b0;
    logic [15:0]   code = '0;
    logic [AW-1:0] attr = '0;
    logic [8:0]    hpos = '0;
    logic [3:0]    ysub = '0;
    logic [ZW-1:0] hzoom = '0;
    logic [31:0]   rom_data = '0;
    logic          dr_busy, rom_cs, buf_we;
    logic [20:0]   rom_addr;
    logic [8:0]    buf_addr;
    logic [AW+3:0] buf_din;

    int          checks = 0, failures = 0;
    wr_t         exp_q[$];
    logic [31:0] w0 = '0, w1 = '0;
    int          stall = 0, busy_cens = 0, nwr = 0, macc = 0;
    logic        cen_mode = 1'b0;
    logic [8:0]  mx = '0;
    logic [19:0] exp_base = '0;

    jt053247_draw #(.ZW(ZW), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .dr_start (dr_start),
        .dr_busy  (dr_busy),
        .code     (code),
        .attr     (attr),
        .hflip    (hflip),
        .vflip    (vflip),
        .hpos     (hpos),
        .ysub     (ysub),
        .hzoom    (hzoom),
        .hz_keep  (hz_keep),
        .rom_addr (rom_addr),
        .rom_cs   (rom_cs),
        .rom_ok   (rom_ok),
        .rom_data (rom_data),
        .buf_addr (buf_addr),
        .buf_we   (buf_we),
        .buf_din  (buf_din)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic on_screen(input logic [8:0] x);
        return !CLIP || x < 9'h180;
    endfunction

    // Reference drawer: integer source position, 64 units per source pixel
    task automatic model(input vec_t v);
        logic [63:0] pw;
        logic [8:0]  x;
        logic [3:0]  p;
        wr_t         w;
        int          a, n, sp, st;
        pw = {v.w1, v.w0};
        st = v.hz == '0 ? 1 : int'(v.hz);
        x  = v.keep ? mx : v.hpos;
        a  = v.keep ? macc % 64 : 0;
        n  = 0;
        do begin
            sp = v.hflip ? 15 - a / 64 : a / 64;
            p  = pw[sp*4 +: 4];
            if (p != 4'd0 && on_screen(x)) begin
                w.a = x;
                w.d = {v.attr, p};
                exp_q.push_back(w);
            end
            x = x + 9'd1;
            a += st;
            n++;
        end while (a < 1024 && n < 512);
        mx   = x;
        macc = a;
    endtask

    // ROM and clock-enable driver: stalls each new address for 'stall' cens
    initial begin
        logic [20:0] last_a;
        logic        have, prev_cen;
        int          wt;
        have = 1'b0;
        prev_cen = 1'b1;
        wt = 0;
        last_a = '0;
        forever begin
            @(posedge clk);
            #1;
            cen = cen_mode ? ~cen : 1'b1;
            if (!rom_cs) begin
                rom_ok = 1'b0;
                have = 1'b0;
            end else begin
                if (!have || rom_addr != last_a) begin
                    have = 1'b1;
                    last_a = rom_addr;
                    wt = 0;
                end else if (prev_cen)
                    wt++;
                rom_ok = wt >= stall;
            end
            rom_data = rom_addr[0] ? w1 : w0;
            prev_cen = cen;
        end
    end

    // Output monitor: scoreboard pops, ROM handshake rules, busy cen count
    initial begin
        logic        p_cs, p_acc;
        logic [20:0] p_addr;
        wr_t         e;
        p_cs = 1'b0;
        p_acc = 1'b0;
        p_addr = '0;
        forever begin
            @(negedge clk);
            if (dr_busy && cen) busy_cens++;
            if (buf_we) begin
                nwr++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_write: x=%0h din=%0h with no write expected", buf_addr, buf_din);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(buf_addr), 32'(e.a));
                    chk("wr_din", 32'(buf_din), 32'(e.d));
                end
            end
            if (rom_cs) chk("rom_addr_base", 32'(rom_addr[20:1]), 32'(exp_base));
            if (p_cs && rom_cs && rom_addr != p_addr)
                chk("rom_addr_step", 32'({p_acc, p_addr[0], rom_addr[0]}), 32'b101);
            if (p_cs && !rom_cs && !rst)
                chk("rom_cs_drop", 32'({p_acc, p_addr[0]}), 32'b11);
            p_cs = rom_cs;
            p_addr = rom_addr;
            p_acc = rom_ok && cen;
        end
    end

    task automatic prep(input vec_t v);
        w0 = v.w0;
        w1 = v.w1;
        stall = v.stall;
        cen_mode = v.cm;
        exp_base = {v.code, v.ysub ^ {4{v.vflip}}};
        busy_cens = 0;
        model(v);
    endtask

    task automatic start_draw(input vec_t v);
        do begin
            @(posedge clk);
            #2;
        end while (!cen);
        code = v.code;
        attr = v.attr;
        hflip = v.hflip;
        vflip = v.vflip;
        hpos = v.hpos;
        ysub = v.ysub;
        hzoom = v.hz;
        hz_keep = v.keep;
        dr_start = 1'b1;
        @(posedge clk);
        #2;
        dr_start = 1'b0;
        chk("busy_rise", 32'(dr_busy), 32'd1);
        chk("rom_cs_rise", 32'(rom_cs), 32'd1);
        code = 16'($urandom);
        attr = AW'($urandom);
        hflip = 1'($urandom);
        vflip = 1'($urandom);
        hpos = 9'($urandom);
        ysub = 4'($urandom);
        hzoom = ZW'($urandom);
        hz_keep = 1'($urandom);
    endtask

    task automatic finish_vec(input vec_t v);
        int n;
        n = 0;
        while (dr_busy && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(n < 4000), 32'd1);
        @(posedge clk);
        #1;
        chk("busy_cens", 32'(busy_cens), 32'(2 + v.n + 2 * v.stall));
        chk("missing_writes", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic run_vec(input vec_t v);
        prep(v);
        start_draw(v);
        finish_vec(v);
    endtask

    initial begin
        vec_t vt[11];
        vec_t v;
        int   n;
        vt[0]  = '{16'h1234, 10'h155, 1'b0, 1'b0, 9'h040, 4'd3, 10'h040, 1'b0, 32'h76543210, 32'hFEDCBA98, 0, 1'b0, 16};
        vt[1]  = '{16'h1234, 10'h2AA, 1'b1, 1'b1, 9'h040, 4'd3, 10'h040, 1'b0, 32'h76543210, 32'hFEDCBA98, 0, 1'b0, 16};
        vt[2]  = '{16'h0ABC, 10'h001, 1'b0, 1'b0, 9'h100, 4'd7, 10'h080, 1'b0, 32'h76543210, 32'hFEDCBA98, 0, 1'b0, 8};
        vt[3]  = '{16'h0ABC, 10'h3FF, 1'b1, 1'b0, 9'h010, 4'd0, 10'h020, 1'b0, 32'h76543210, 32'hFEDCBA98, 0, 1'b0, 32};
        vt[4]  = '{16'h5555, 10'h123, 1'b0, 1'b1, 9'h1F0, 4'd9, 10'h000, 1'b0, 32'h76543210, 32'hFEDCBA98, 0, 1'b0, 512};
        vt[5]  = '{16'h00FF, 10'h0F0, 1'b0, 1'b0, 9'h1F8, 4'd5, 10'h030, 1'b0, 32'h76543210, 32'hFEDCBA98, 0, 1'b0, 22};
        vt[6]  = '{16'h00FF, 10'h0F1, 1'b1, 1'b0, 9'h100, 4'd5, 10'h030, 1'b1, 32'h76543210, 32'hFEDCBA98, 0, 1'b0, 21};
        vt[7]  = '{16'hBEEF, 10'h200, 1'b0, 1'b0, 9'h0C0, 4'd15, 10'h040, 1'b0, 32'h0F0E0D00, 32'h00A0B0C1, 5, 1'b0, 16};
        vt[8]  = '{16'hCAFE, 10'h111, 1'b0, 1'b0, 9'h0A0, 4'd2, 10'h055, 1'b0, 32'h12345678, 32'h9ABCDEF0, 0, 1'b1, 13};
        vt[9]  = '{16'h0001, 10'h3A5, 1'b1, 1'b0, 9'h1FA, 4'd1, 10'h040, 1'b0, 32'h89ABCDEF, 32'h01234567, 3, 1'b1, 16};
        vt[10] = '{16'h0777, 10'h0C3, 1'b0, 1'b0, 9'h17C, 4'd4, 10'h040, 1'b0, 32'h11111111, 32'h11111111, 0, 1'b0, 16};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(dr_busy), 32'd0);
        chk("rst_rom_cs", 32'(rom_cs), 32'd0);
        chk("rst_buf_we", 32'(buf_we), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_buf_addr", 32'(buf_addr), 32'd0);
        chk("rst_buf_din", 32'(buf_din), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        for (int i = 0; i < 11; i++) run_vec(vt[i]);

        // dr_start while drawing must be ignored
        v = vt[0];
        v.attr = 10'h0AA;
        prep(v);
        start_draw(v);
        n = 0;
        while (!(dr_busy && !rom_cs) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reach_draw", 32'(n < 50), 32'd1);
        code = 16'hDEAD;
        hpos = 9'h000;
        dr_start = 1'b1;
        @(posedge clk);
        #2;
        dr_start = 1'b0;
        finish_vec(v);
        repeat (4) begin
            @(negedge clk);
            chk("no_restart", 32'(dr_busy), 32'd0);
        end

        // reset in the middle of a draw
        v = vt[0];
        v.hz = 10'h030;
        prep(v);
        start_draw(v);
        nwr = 0;
        n = 0;
        while (nwr < 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mid_draw_reached", 32'(nwr >= 3), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_busy", 32'(dr_busy), 32'd0);
        chk("mid_rst_buf_we", 32'(buf_we), 32'd0);
        chk("mid_rst_rom_cs", 32'(rom_cs), 32'd0);
        chk("mid_rst_buf_addr", 32'(buf_addr), 32'd0);
        chk("mid_rst_buf_din", 32'(buf_din), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        exp_q.delete();
        mx = '0;
        macc = 0;

        // continuation right after reset starts from x = 0
        v = '{16'h0042, 10'h321, 1'b0, 1'b0, 9'h0AB, 4'd6, 10'h040, 1'b1, 32'h76543210, 32'hFEDCBA98, 0, 1'b0, 16};
        run_vec(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
